// File: rtl/conv_accum_core_if.sv
// conv_accum_core_if -- beat input and result output bundle for conv_accum_core.
//   in_valid/clr    : beat strobe and synchronous abort
//   win/kern        : 3x3 unsigned window / signed kernel, element (r,c) at 3r+c, LSB-first
//   x/y             : pixel coordinate (taken from the first channel beat)
//   bias/relu_en    : signed bias and negative clamp (taken from the last channel beat)
//   out_*           : registered result, coordinate and saturation flag
interface conv_accum_core_if #(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 16
);
  logic                      in_valid;
  logic                      clr;
  logic [9*PIX_W-1:0]        win;
  logic [9*COEF_W-1:0]       kern;
  logic [10:0]               x;
  logic [9:0]                y;
  logic signed [15:0]        bias;
  logic                      relu_en;
  logic                      out_valid;
  logic signed [OUT_W-1:0]   out_data;
  logic [10:0]               out_x;
  logic [9:0]                out_y;
  logic                      out_sat;

  modport master (
    output in_valid, clr, win, kern, x, y, bias, relu_en,
    input  out_valid, out_data, out_x, out_y, out_sat
  );

  modport slave (
    input  in_valid, clr, win, kern, x, y, bias, relu_en,
    output out_valid, out_data, out_x, out_y, out_sat
  );
endinterface

// File: rtl/conv_accum_core.sv
// conv_accum_core -- 3x3 convolution MAC accumulated over C_IN channel beats.
//   clk   : single clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : conv_accum_core_if slave (beat inputs, result outputs)
// Pipeline: sample -> S1 products -> S2 row sums -> S3 window sum -> S4 accumulate
// -> output (bias, rounding shift, relu, saturate). A last beat sampled on edge N
// shows out_valid after edge N+4.
module conv_accum_core #(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8,
  parameter int C_IN   = 4,
  parameter int SHIFT  = 0,
  parameter int OUT_W  = 16
) (
  input logic               clk,
  input logic               reset,
  conv_accum_core_if.slave  bus
);

  localparam int PROD_W = PIX_W + COEF_W + 1;
  localparam int ROW_W  = PROD_W + 2;
  localparam int WIN_W  = PROD_W + 4;
  localparam int ACC_W  = WIN_W + $clog2(C_IN) + 1;
  localparam int CNT_W  = (C_IN > 1) ? $clog2(C_IN) : 1;
  localparam int T_B0   = (ACC_W > 16) ? ACC_W : 16;
  localparam int T_B1   = (T_B0 > OUT_W) ? T_B0 : OUT_W;
  // Two spare bits keep bias add and rounding add free of overflow.
  localparam int T_W    = T_B1 + 2;
  localparam int SH_M1  = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [T_W-1:0] RND =
    (SHIFT > 0) ? ({{(T_W-1){1'b0}}, 1'b1} << SH_M1) : '0;
  localparam logic signed [T_W-1:0] MAX_V = {{(T_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [T_W-1:0] MIN_V = {{(T_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef struct packed {
    logic               first;
    logic               last;
    logic [10:0]        x;
    logic [9:0]         y;
    logic signed [15:0] bias;
    logic               relu;
  } meta_t;

  // Sampling
  logic             take;
  logic             first_beat;
  logic             last_beat;
  logic [CNT_W-1:0] ch_cnt_d, ch_cnt_q;
  logic [10:0]      x_hold_d, x_hold_q;
  logic [9:0]       y_hold_d, y_hold_q;

  // Pipeline stages
  logic                     s1_valid_d, s1_valid_q;
  meta_t                    s1_meta_d, s1_meta_q;
  logic signed [PROD_W-1:0] prod_d [9];
  logic signed [PROD_W-1:0] prod_q [9];

  logic                     s2_valid_d, s2_valid_q;
  meta_t                    s2_meta_d, s2_meta_q;
  logic signed [ROW_W-1:0]  row_d [3];
  logic signed [ROW_W-1:0]  row_q [3];

  logic                     s3_valid_d, s3_valid_q;
  meta_t                    s3_meta_d, s3_meta_q;
  logic signed [WIN_W-1:0]  win_d, win_q;

  logic                     s4_valid_d, s4_valid_q;
  logic                     s4_last_d, s4_last_q;
  logic [10:0]              s4_x_d, s4_x_q;
  logic [9:0]               s4_y_d, s4_y_q;
  logic signed [15:0]       s4_bias_d, s4_bias_q;
  logic                     s4_relu_d, s4_relu_q;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  acc_d, acc_q;

  // Output stage
  logic signed [T_W-1:0]    t_sum, t_shr, t_rel, t_sat;
  logic                     sat;
  logic                     out_valid_d, out_valid_q;
  logic signed [OUT_W-1:0]  out_data_d, out_data_q;
  logic [10:0]              out_x_d, out_x_q;
  logic [9:0]               out_y_d, out_y_q;
  logic                     out_sat_d, out_sat_q;

  always_comb begin : sample_c
    take       = bus.in_valid & ~bus.clr;
    first_beat = (ch_cnt_q == '0);
    last_beat  = (ch_cnt_q == CNT_W'(C_IN - 1));
    ch_cnt_d   = ch_cnt_q;
    x_hold_d   = x_hold_q;
    y_hold_d   = y_hold_q;
    if (bus.clr) begin
      ch_cnt_d = '0;
    end else if (bus.in_valid) begin
      ch_cnt_d = last_beat ? '0 : ch_cnt_q + CNT_W'(1);
      if (first_beat) begin
        x_hold_d = bus.x;
        y_hold_d = bus.y;
      end
    end
    s1_valid_d      = take;
    s1_meta_d.first = first_beat;
    s1_meta_d.last  = last_beat;
    // With C_IN=1 the only beat is also the first, so take the live coordinate.
    s1_meta_d.x     = first_beat ? bus.x : x_hold_q;
    s1_meta_d.y     = first_beat ? bus.y : y_hold_q;
    s1_meta_d.bias  = bus.bias;
    s1_meta_d.relu  = bus.relu_en;
    for (int i = 0; i < 9; i++) begin
      prod_d[i] = PROD_W'($signed({1'b0, bus.win[i*PIX_W +: PIX_W]}))
                * PROD_W'($signed(bus.kern[i*COEF_W +: COEF_W]));
    end
  end

  always_comb begin : pipe_c
    s2_valid_d = s1_valid_q & ~bus.clr;
    s2_meta_d  = s1_meta_q;
    for (int r = 0; r < 3; r++) begin
      row_d[r] = ROW_W'(prod_q[3*r]) + ROW_W'(prod_q[3*r+1]) + ROW_W'(prod_q[3*r+2]);
    end
    s3_valid_d = s2_valid_q & ~bus.clr;
    s3_meta_d  = s2_meta_q;
    win_d      = WIN_W'(row_q[0]) + WIN_W'(row_q[1]) + WIN_W'(row_q[2]);

    acc_next   = (s3_meta_q.first ? '0 : acc_q) + ACC_W'(win_q);
    acc_d      = acc_q;
    if (bus.clr)         acc_d = '0;
    else if (s3_valid_q) acc_d = acc_next;
    s4_valid_d = s3_valid_q & ~bus.clr;
    s4_last_d  = s3_meta_q.last;
    s4_x_d     = s3_meta_q.x;
    s4_y_d     = s3_meta_q.y;
    s4_bias_d  = s3_meta_q.bias;
    s4_relu_d  = s3_meta_q.relu;
  end

  // acc_q holds the completed channel sum for one cycle after the last beat;
  // a following first beat overwrites it on the same edge the output captures it.
  always_comb begin : out_c
    t_sum = T_W'(acc_q) + T_W'(s4_bias_q);
    t_shr = (t_sum + RND) >>> SHIFT;
    t_rel = (s4_relu_q && t_shr[T_W-1]) ? '0 : t_shr;
    t_sat = t_rel;
    sat   = 1'b0;
    if (t_rel > MAX_V) begin
      t_sat = MAX_V;
      sat   = 1'b1;
    end else if (t_rel < MIN_V) begin
      t_sat = MIN_V;
      sat   = 1'b1;
    end
    out_valid_d = s4_valid_q & s4_last_q & ~bus.clr;
    out_data_d  = out_data_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_sat_d   = out_sat_q;
    if (out_valid_d) begin
      out_data_d = t_sat[OUT_W-1:0];
      out_x_d    = s4_x_q;
      out_y_d    = s4_y_q;
      out_sat_d  = sat;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch_cnt_q    <= '0;
      x_hold_q    <= '0;
      y_hold_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_meta_q   <= '0;
      for (int i = 0; i < 9; i++) prod_q[i] <= '0;
      s2_valid_q  <= 1'b0;
      s2_meta_q   <= '0;
      for (int r = 0; r < 3; r++) row_q[r] <= '0;
      s3_valid_q  <= 1'b0;
      s3_meta_q   <= '0;
      win_q       <= '0;
      s4_valid_q  <= 1'b0;
      s4_last_q   <= 1'b0;
      s4_x_q      <= '0;
      s4_y_q      <= '0;
      s4_bias_q   <= '0;
      s4_relu_q   <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      ch_cnt_q    <= ch_cnt_d;
      x_hold_q    <= x_hold_d;
      y_hold_q    <= y_hold_d;
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s3_valid_q  <= s3_valid_d;
      s4_valid_q  <= s4_valid_d;
      acc_q       <= acc_d;
      if (take) begin
        s1_meta_q <= s1_meta_d;
        for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
      end
      if (s1_valid_q) begin
        s2_meta_q <= s2_meta_d;
        for (int r = 0; r < 3; r++) row_q[r] <= row_d[r];
      end
      if (s2_valid_q) begin
        s3_meta_q <= s3_meta_d;
        win_q     <= win_d;
      end
      if (s3_valid_q) begin
        s4_last_q <= s4_last_d;
        s4_x_q    <= s4_x_d;
        s4_y_q    <= s4_y_d;
        s4_bias_q <= s4_bias_d;
        s4_relu_q <= s4_relu_d;
      end
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_conv_accum_core.sv
// tb_conv_accum_core -- three conv_accum_core instances share one beat stream:
//   dut0: C_IN=4 SHIFT=0, dut1: C_IN=1 SHIFT=0, dut2: C_IN=1 SHIFT=2.
// A behavioural model pushes expected results (with due cycle) into per-instance
// queues; a negedge monitor pops and compares them and checks hold behaviour.
module tb_conv_accum_core;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic               in_valid = 1'b0;
  logic               clr = 1'b0;
  logic [71:0]        win_v = '0;
  logic [71:0]        kern_v = '0;
  logic [10:0]        x_v = '0;
  logic [9:0]         y_v = '0;
  logic signed [15:0] bias_v = '0;
  logic               relu_v = 1'b0;

  logic               ov [3];
  logic signed [15:0] od [3];
  logic [10:0]        ox [3];
  logic [9:0]         oy [3];
  logic               osat [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    conv_accum_core_if #(.PIX_W(8), .COEF_W(8), .OUT_W(16)) bus ();
    assign bus.in_valid = in_valid;
    assign bus.clr      = clr;
    assign bus.win      = win_v;
    assign bus.kern     = kern_v;
    assign bus.x        = x_v;
    assign bus.y        = y_v;
    assign bus.bias     = bias_v;
    assign bus.relu_en  = relu_v;
    assign ov[g]   = bus.out_valid;
    assign od[g]   = bus.out_data;
    assign ox[g]   = bus.out_x;
    assign oy[g]   = bus.out_y;
    assign osat[g] = bus.out_sat;
    conv_accum_core #(
      .PIX_W(8), .COEF_W(8), .C_IN(g == 0 ? 4 : 1), .SHIFT(g == 2 ? 2 : 0), .OUT_W(16)
    ) u_dut (
      .clk(clk),
      .reset(rst_n),
      .bus(bus)
    );
  end

  typedef struct {
    int     due;
    longint data;
    int     x;
    int     y;
    bit     sat;
  } exp_t;

  exp_t   sbq [3][$];
  exp_t   last_out [3];
  int     out_cnt [3];
  int     m_ch [3];
  longint m_acc [3];
  int     m_x [3];
  int     m_y [3];
  int     checks = 0;
  int     errors = 0;

  logic [71:0] all1, all10, all255, k127, km1;

  function automatic int cin_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int sh_of(input int d);
    return (d == 2) ? 2 : 0;
  endfunction

  function automatic exp_t calc(input int d, input longint acc, input int b, input bit relu,
                                input int x, input int y, input int due);
    exp_t   e;
    longint t;
    int     sh;
    sh = sh_of(d);
    t  = acc + longint'(b);
    if (sh > 0) t = (t + (64'sd1 <<< (sh - 1))) >>> sh;
    if (relu && t < 0) t = 0;
    e.sat = 1'b0;
    if (t > 32767) begin
      t = 32767;
      e.sat = 1'b1;
    end else if (t < -32768) begin
      t = -32768;
      e.sat = 1'b1;
    end
    e.data = t;
    e.x    = x;
    e.y    = y;
    e.due  = due;
    return e;
  endfunction

  // Called while inputs are stable, before the edge that samples them (edge cyc+1).
  task automatic model_beat(input bit v, input bit c);
    int     e_edge;
    longint ws;
    int     pv;
    byte    kv;
    e_edge = cyc + 1;
    for (int d = 0; d < 3; d++) begin
      if (c) begin
        m_ch[d]  = 0;
        m_acc[d] = 0;
        while (sbq[d].size() > 0 && sbq[d][$].due >= e_edge) void'(sbq[d].pop_back());
      end else if (v) begin
        ws = 0;
        for (int i = 0; i < 9; i++) begin
          pv = int'(win_v[8*i +: 8]);
          kv = kern_v[8*i +: 8];
          ws += longint'(pv * int'(kv));
        end
        if (m_ch[d] == 0) begin
          m_acc[d] = ws;
          m_x[d]   = int'(x_v);
          m_y[d]   = int'(y_v);
        end else begin
          m_acc[d] += ws;
        end
        if (m_ch[d] == cin_of(d) - 1) begin
          sbq[d].push_back(calc(d, m_acc[d], int'(bias_v), relu_v, m_x[d], m_y[d], e_edge + 4));
          m_ch[d] = 0;
        end else begin
          m_ch[d]++;
        end
      end
    end
  endtask

  task automatic beat(input logic [71:0] w, input logic [71:0] k, input int x, input int y,
                      input int b, input bit relu, input bit v, input bit c);
    in_valid = v;
    clr      = c;
    win_v    = w;
    kern_v   = k;
    x_v      = 11'(x);
    y_v      = 10'(y);
    bias_v   = 16'(b);
    relu_v   = relu;
    model_beat(v, c);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      sbq[d].delete();
      m_ch[d]     = 0;
      m_acc[d]    = 0;
      last_out[d] = '{due: 0, data: 0, x: 0, y: 0, sat: 1'b0};
    end
  endtask

  function automatic logic [71:0] rnd72();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[71:0];
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        while (sbq[d].size() > 0 && sbq[d][0].due < cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_out dut%0d got none required data=%0d due=%0d now=%0d",
                   d, sbq[d][0].data, sbq[d][0].due, cyc);
          void'(sbq[d].pop_front());
        end
        checks++;
        if (ov[d]) begin
          if (sbq[d].size() == 0 || sbq[d][0].due != cyc) begin
            errors++;
            $display("FAIL unexpected_out dut%0d got data=%0d x=%0d at cycle %0d required no output",
                     d, od[d], ox[d], cyc);
          end else begin
            exp_t e;
            e = sbq[d].pop_front();
            out_cnt[d]++;
            if (od[d] !== 16'(e.data) || ox[d] !== 11'(e.x) || oy[d] !== 10'(e.y) || osat[d] !== e.sat) begin
              errors++;
              $display("FAIL out_value dut%0d got data=%0d x=%0d y=%0d sat=%0d required data=%0d x=%0d y=%0d sat=%0d",
                       d, od[d], ox[d], oy[d], osat[d], e.data, e.x, e.y, e.sat);
            end
            last_out[d] = e;
          end
        end else if (od[d] !== 16'(last_out[d].data) || ox[d] !== 11'(last_out[d].x) ||
                     oy[d] !== 10'(last_out[d].y) || osat[d] !== last_out[d].sat) begin
          errors++;
          $display("FAIL hold dut%0d got data=%0d x=%0d y=%0d sat=%0d required data=%0d x=%0d y=%0d sat=%0d",
                   d, od[d], ox[d], oy[d], osat[d], last_out[d].data, last_out[d].x,
                   last_out[d].y, last_out[d].sat);
        end
      end
    end
  end

  task automatic test_reset();
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ov[d] !== 1'b0 || od[d] !== 16'sd0 || ox[d] !== 11'd0 || oy[d] !== 10'd0 || osat[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got v=%0d data=%0d x=%0d y=%0d sat=%0d required all 0",
                 d, ov[d], od[d], ox[d], oy[d], osat[d]);
      end
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    int c1;
    c1 = out_cnt[1];
    beat(all1, all1, 5, 7, 0, 1'b0, 1'b1, 1'b0);
    idle(8);
    checks++;
    if (out_cnt[1] - c1 !== 1 || od[1] !== 16'sd9 || ox[1] !== 11'd5 || oy[1] !== 10'd7 || osat[1] !== 1'b0) begin
      errors++;
      $display("FAIL basic dut1 got n=%0d data=%0d x=%0d y=%0d sat=%0d required n=1 data=9 x=5 y=7 sat=0",
               out_cnt[1] - c1, od[1], ox[1], oy[1], osat[1]);
    end
    checks++;
    if (od[2] !== 16'sd2) begin
      errors++;
      $display("FAIL basic_shift dut2 got %0d required 2", od[2]);
    end
  endtask

  task automatic test_saturate();
    beat(all1, all1, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) beat(all255, k127, 3, 4, 0, 1'b0, 1'b1, 1'b0);
    idle(8);
    checks++;
    if (od[0] !== 16'sd32767 || osat[0] !== 1'b1 || ox[0] !== 11'd3) begin
      errors++;
      $display("FAIL saturate dut0 got data=%0d sat=%0d x=%0d required data=32767 sat=1 x=3",
               od[0], osat[0], ox[0]);
    end
  endtask

  task automatic test_relu();
    beat(all1, all1, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    beat(all10, km1, 1, 1, 0, 1'b0, 1'b1, 1'b0);
    idle(6);
    checks++;
    if (od[1] !== -16'sd90 || osat[1] !== 1'b0) begin
      errors++;
      $display("FAIL relu_off dut1 got data=%0d sat=%0d required -90 0", od[1], osat[1]);
    end
    beat(all10, km1, 2, 2, 0, 1'b1, 1'b1, 1'b0);
    idle(6);
    checks++;
    if (od[1] !== 16'sd0 || osat[1] !== 1'b0) begin
      errors++;
      $display("FAIL relu_on dut1 got data=%0d sat=%0d required 0 0", od[1], osat[1]);
    end
  endtask

  task automatic test_shift();
    logic [71:0] w, kp, kn;
    w  = 72'd10;
    kp = 72'd1;
    kn = 72'hFF;
    beat(w, kp, 1, 1, 0, 1'b0, 1'b1, 1'b0);
    idle(6);
    checks++;
    if (od[2] !== 16'sd3) begin
      errors++;
      $display("FAIL shift_pos dut2 got %0d required 3", od[2]);
    end
    beat(w, kn, 1, 1, 0, 1'b0, 1'b1, 1'b0);
    idle(6);
    checks++;
    if (od[2] !== -16'sd2) begin
      errors++;
      $display("FAIL shift_neg dut2 got %0d required -2", od[2]);
    end
  endtask

  task automatic test_clr();
    int c0;
    beat(all1, all1, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    c0 = out_cnt[0];
    beat(all255, k127, 9, 9, 0, 1'b0, 1'b1, 1'b0);
    beat(all255, k127, 9, 9, 0, 1'b0, 1'b1, 1'b0);
    beat(all255, k127, 9, 9, 0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) beat(all1, all1, 20 + i, 30 + i, 0, 1'b0, 1'b1, 1'b0);
    idle(8);
    checks++;
    if (out_cnt[0] - c0 !== 1 || od[0] !== 16'sd36 || ox[0] !== 11'd20 || oy[0] !== 10'd30) begin
      errors++;
      $display("FAIL clr dut0 got n=%0d data=%0d x=%0d y=%0d required n=1 data=36 x=20 y=30",
               out_cnt[0] - c0, od[0], ox[0], oy[0]);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    beat(all1, all1, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    c0 = out_cnt[0];
    for (int i = 0; i < 8; i++)
      beat(rnd72(), rnd72(), 100 + i, 200 + i, int'($urandom_range(0, 65535)) - 32768,
           1'($urandom_range(0, 1)), 1'b1, 1'b0);
    idle(10);
    checks++;
    if (out_cnt[0] - c0 !== 2 || ox[0] !== 11'd104 || oy[0] !== 10'd204) begin
      errors++;
      $display("FAIL back_to_back dut0 got n=%0d x=%0d y=%0d required n=2 x=104 y=204",
               out_cnt[0] - c0, ox[0], oy[0]);
    end
  endtask

  task automatic test_reset_inflight();
    int c0;
    beat(all1, all1, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) beat(all1, all1, 50 + i, 60, 0, 1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ov[d] !== 1'b0 || od[d] !== 16'sd0 || ox[d] !== 11'd0 || osat[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_inflight dut%0d got v=%0d data=%0d x=%0d sat=%0d required all 0",
                 d, ov[d], od[d], ox[d], osat[d]);
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(8);
    c0 = out_cnt[0];
    for (int i = 0; i < 4; i++) beat(all1, all1, 70 + i, 80, 5, 1'b0, 1'b1, 1'b0);
    idle(8);
    checks++;
    if (out_cnt[0] - c0 !== 1 || od[0] !== 16'sd41 || ox[0] !== 11'd70) begin
      errors++;
      $display("FAIL post_reset dut0 got n=%0d data=%0d x=%0d required n=1 data=41 x=70",
               out_cnt[0] - c0, od[0], ox[0]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 120; i++)
      beat(rnd72(), rnd72(), int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)),
           int'($urandom_range(0, 65535)) - 32768, 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
    idle(10);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (sbq[d].size() != 0) begin
        errors++;
        $display("FAIL drain dut%0d got %0d pending required 0", d, sbq[d].size());
      end
    end
  endtask

  initial begin
    all1   = {9{8'd1}};
    all10  = {9{8'd10}};
    all255 = {9{8'd255}};
    k127   = {9{8'd127}};
    km1    = {9{8'hFF}};
    for (int d = 0; d < 3; d++) out_cnt[d] = 0;
    test_reset();
    test_basic();
    test_saturate();
    test_relu();
    test_shift();
    test_clr();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/conv_accum_core.md
CONV_ACCUM_CORE -- requirements
Module: conv_accum_core

Interface
REQ-001 SHALL have parameter PIX_W, default 8: unsigned pixel width.
REQ-002 SHALL have parameter COEF_W, default 8: signed kernel coefficient width.
REQ-003 SHALL have parameter C_IN, default 4, legal range >=1: input channels accumulated per output pixel.
REQ-004 SHALL have parameter SHIFT, default 0, legal range >=0: rounding right-shift applied before output.
REQ-005 SHALL have parameter OUT_W, default 16: signed output width.
REQ-006 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port in_valid, input, 1: one channel beat presented this cycle.
REQ-009 SHALL have port clr, input, 1: synchronous abort of partial accumulation and in-flight data.
REQ-010 SHALL have port win, input, 9*PIX_W: unsigned 3x3 window, element (r,c) at index 3r+c, LSB-first.
REQ-011 SHALL have port kern, input, 9*COEF_W: signed 3x3 kernel, same packing.
REQ-012 SHALL have port x / y, input, 11 / 10: pixel coordinate.
REQ-013 SHALL have port bias, input, 16: signed bias.
REQ-014 SHALL have port relu_en, input, 1: clamp negative results to zero.
REQ-015 SHALL have ports out_valid (output, 1), out_data (output, OUT_W, signed), out_x (output, 11), out_y (output, 10), out_sat (output, 1: result was clamped).

Function
REQ-016 SHALL sample a beat on a rising edge where in_valid=1 and clr=0; beats may arrive every cycle or with gaps.
REQ-017 SHALL maintain channel counter ch_cnt (0..C_IN-1), incremented per sampled beat, wrapping from C_IN-1 to 0; beat tagged first when ch_cnt=0 and last when ch_cnt=C_IN-1 (both when C_IN=1).
REQ-018 SHALL capture x, y at the first beat; bias and relu_en at the last beat; carry them with the data.
REQ-019 Stage 1 SHALL register 9 products: zero-extended pixel (PIX_W+1 bits, signed) times kern element; PROD_W = PIX_W+COEF_W+1.
REQ-020 Stage 2 SHALL register three row sums; stage 3 SHALL register the window sum, width PROD_W+4, with no overflow.
REQ-021 Stage 4 SHALL form acc_next = (first ? 0 : acc) + window_sum; ACC_W = PROD_W+4+clog2(C_IN)+1, no overflow; acc <= acc_next.
REQ-022 On a last-tagged stage-4 beat, the output stage SHALL compute:
- t = acc_next + sign-extended bias
- if SHIFT>0: t = (t + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift)
- if relu_en and t<0: t = 0
- saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1], out_sat = 1 iff clamped.
REQ-023 Latency: a last beat sampled on edge N SHALL produce out_valid=1 for exactly one cycle after edge N+4, with out_data, out_x, out_y, out_sat valid in the same cycle.
REQ-024 out_data, out_x, out_y, out_sat SHALL hold their last values while out_valid=0.
REQ-025 Throughput: one beat per cycle sustained with no stall; no backpressure input exists.
REQ-026 clr=1 SHALL zero ch_cnt and acc and invalidate all stage valid bits on that edge; no output results from any beat sampled before it; clr with in_valid in the same cycle SHALL drop the beat.
REQ-027 Non-last beats SHALL never assert out_valid.

Reset
REQ-028 reset=0 SHALL immediately force out_valid=0, out_sat=0, out_data=0, out_x=0, out_y=0, ch_cnt=0, acc=0, and all stage valid bits to 0, regardless of clk.
REQ-029 After reset release, the first sampled beat SHALL be tagged first; no output from pre-reset beats ever appears.

Verification
REQ-030 C_IN=1, SHIFT=0, win all 1, kern all 1, bias 0, x=5, y=7 sampled on edge N -> out_valid after edge N+4, out_data=9, out_x=5, out_y=7, out_sat=0.
REQ-031 C_IN=4, OUT_W=16, four beats with win all 255, kern all 127 -> raw sum 1165860, out_data=32767, out_sat=1.
REQ-032 C_IN=1, win all 10, kern all -1, bias 0: relu_en=0 -> out_data=-90; relu_en=1 -> out_data=0, out_sat=0.
REQ-033 SHIFT=2, pre-shift sum +10 -> out_data 3; pre-shift sum -10 -> out_data -2.
REQ-034 C_IN=4, 2 beats, clr pulse, then 4 beats of win all 1, kern all 1 -> exactly one output, out_data=36; 8 back-to-back beats on edges N..N+7 -> outputs after edges N+7 and N+11, coordinates from beats N and N+4.
REQ-035 reset asserted with the pipeline full -> out_valid=0 immediately; no out_valid for any pre-reset beat after release.
